// File: rtl/mesh_terminal_port_pkg.sv
// mesh_pkg: definitions shared by the terminal port and the mesh bench.
//   ID_W       width of the destination id {row[3:0], col[3:0]}
//   CNT_W      width of the tx/rx packet counters
//   MAX_PKT_W  widest packet dest_of() can accept
//   rx_state_t receive-side FSM states
//   dest_of()  destination id field (top ID_W bits) of a packet pkt_w bits wide
package mesh_pkg;

  localparam int ID_W      = 8;
  localparam int CNT_W     = 16;
  localparam int MAX_PKT_W = 256;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_POP  = 2'd1,
    RX_HOLD = 2'd2
  } rx_state_t;

  // The packet is passed zero-extended to MAX_PKT_W, so the id is found by
  // shifting the real packet width down rather than by a fixed slice.
  function automatic logic [ID_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                              input int pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/mesh_terminal_port_if.sv
// mesh_terminal_port_if: every handshake/data signal of one mesh terminal port.
//   Host TX : wr_en, wr_data -> ; <- full
//   Mesh TX : <- data_out_i_in, pndng_i_in ; popin ->
//   Mesh RX : pndng, data_out -> ; <- pop
//   Host RX : <- rx_valid, rx_data, rx_bcst, rx_misroute ; rx_ready ->
//   Status  : <- tx_cnt, rx_cnt
// slave is the terminal port itself, master is whatever surrounds it.
interface mesh_terminal_port_if
  import mesh_pkg::*;
#(
  parameter int pckg_sz = 40
);

  logic               wr_en;
  logic [pckg_sz-1:0] wr_data;
  logic               full;
  logic [pckg_sz-1:0] data_out_i_in;
  logic               pndng_i_in;
  logic               popin;
  logic               pndng;
  logic [pckg_sz-1:0] data_out;
  logic               pop;
  logic               rx_valid;
  logic [pckg_sz-1:0] rx_data;
  logic               rx_ready;
  logic               rx_bcst;
  logic               rx_misroute;
  logic [CNT_W-1:0]   tx_cnt;
  logic [CNT_W-1:0]   rx_cnt;

  modport slave (
    input  wr_en, wr_data, popin, pndng, data_out, rx_ready,
    output full, data_out_i_in, pndng_i_in, pop, rx_valid, rx_data,
           rx_bcst, rx_misroute, tx_cnt, rx_cnt
  );

  modport master (
    output wr_en, wr_data, popin, pndng, data_out, rx_ready,
    input  full, data_out_i_in, pndng_i_in, pop, rx_valid, rx_data,
           rx_bcst, rx_misroute, tx_cnt, rx_cnt
  );

endinterface

// File: rtl/mesh_terminal_port_tx_fifo.sv
// term_tx_fifo: first-word-fall-through FIFO feeding packets into the mesh.
//   clk, reset  clock / async active-low reset
//   wr_en       host write strobe, wr_data the packet
//   popin       mesh consumes the head this cycle
//   full        count == fifo_depth
//   head        current head, zero while empty
//   pndng       FIFO non-empty
//   tx_cnt      packets actually consumed by the mesh (wraps)
module term_tx_fifo
  import mesh_pkg::*;
#(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [pckg_sz-1:0] wr_data,
  input  logic               popin,
  output logic               full,
  output logic [pckg_sz-1:0] head,
  output logic               pndng,
  output logic [CNT_W-1:0]   tx_cnt
);

  localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CW    = $clog2(fifo_depth + 1);

  logic [pckg_sz-1:0] mem_q [fifo_depth];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic               do_wr, do_pop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(fifo_depth - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CW'(fifo_depth));
  assign pndng = (count_q != '0);
  assign head  = pndng ? mem_q[rd_ptr_q] : '0;
  assign tx_cnt = tx_cnt_q;

  always_comb begin
    do_pop   = popin && pndng;
    // A write into a full FIFO is fine when the head leaves on the same edge.
    do_wr    = wr_en && (!full || do_pop);
    wr_ptr_d = do_wr  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    tx_cnt_d = do_pop ? tx_cnt_q + CNT_W'(1) : tx_cnt_q;
    count_d  = count_q;
    case ({do_wr, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // Storage is not reset; an empty FIFO masks it through head.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/mesh_terminal_port.sv
// mesh_terminal_port: terminal-side adapter for one port of the mesh.
//   clk, reset  clock / async active-low reset
//   bus         mesh_terminal_port_if.slave: host TX write, mesh TX FWFT
//               head, mesh RX drain (pndng/data_out/pop), host RX
//               valid/ready hand-off with flags, tx/rx packet counters
//
// RX FSM:
//   state   | meaning
//   RX_IDLE | nothing held, waiting for mesh pndng
//   RX_POP  | pop high this cycle, data_out captured at the closing edge
//   RX_HOLD | rx_data valid, waiting for rx_ready
module mesh_terminal_port
  import mesh_pkg::*;
#(
  parameter int              ROWS       = 4,
  parameter int              COLUMS     = 4,
  parameter int              pckg_sz    = 40,
  parameter int              fifo_depth = 4,
  parameter logic [ID_W-1:0] bdcst      = 8'hFF,
  parameter logic [ID_W-1:0] TERM_ID    = 8'h00
) (
  input logic                  clk,
  input logic                  reset,
  mesh_terminal_port_if.slave  bus
);

  // Ids carry 4-bit row/column fields; anything outside that cannot be addressed.
  if (fifo_depth < 2 || ROWS < 1 || ROWS > 16 || COLUMS < 1 || COLUMS > 16 ||
      pckg_sz < ID_W || pckg_sz > MAX_PKT_W) begin : g_bad_cfg
    $error("mesh_terminal_port: unsupported parameter set");
  end

  term_tx_fifo #(
    .pckg_sz    (pckg_sz),
    .fifo_depth (fifo_depth)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .popin   (bus.popin),
    .full    (bus.full),
    .head    (bus.data_out_i_in),
    .pndng   (bus.pndng_i_in),
    .tx_cnt  (bus.tx_cnt)
  );

  rx_state_t          state_q, state_d;
  logic               pop_q, pop_d;
  logic               rx_valid_q, rx_valid_d;
  logic [pckg_sz-1:0] rx_data_q, rx_data_d;
  logic               rx_bcst_q, rx_bcst_d;
  logic               rx_mis_q, rx_mis_d;
  logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [ID_W-1:0]    dest;

  assign dest = dest_of(MAX_PKT_W'(bus.data_out), pckg_sz);

  always_comb begin
    state_d    = state_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_bcst_d  = rx_bcst_q;
    rx_mis_d   = rx_mis_q;
    rx_cnt_d   = rx_cnt_q;
    case (state_q)
      RX_IDLE: begin
        if (bus.pndng) state_d = RX_POP;
      end
      RX_POP: begin
        rx_data_d  = bus.data_out;
        rx_bcst_d  = (dest == bdcst);
        rx_mis_d   = (dest != TERM_ID) && (dest != bdcst);
        rx_valid_d = 1'b1;
        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        state_d    = RX_HOLD;
      end
      RX_HOLD: begin
        if (bus.rx_ready) begin
          rx_valid_d = 1'b0;
          state_d    = bus.pndng ? RX_POP : RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
    // pop is registered so the mesh sees a glitch-free one-cycle pulse.
    pop_d = (state_d == RX_POP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RX_IDLE;
      pop_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_bcst_q  <= 1'b0;
      rx_mis_q   <= 1'b0;
      rx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      pop_q      <= pop_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_bcst_q  <= rx_bcst_d;
      rx_mis_q   <= rx_mis_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  assign bus.pop         = pop_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_bcst     = rx_bcst_q;
  assign bus.rx_misroute = rx_mis_q;
  assign bus.rx_cnt      = rx_cnt_q;

endmodule
